reglk_ctrl: RTL
===============

Name: reglk_ctrl

Overview:
Owns the register-lock array (reglk) that gates writes to protected peripheral registers. Arbitrates lock-word update requests from the firmware master and the JTAG debug master, and sequences the lock lifecycle: boot-locked, configure, sealed, debug. Forces every lock word to all-ones on reset and on every debug-mode transition, so no window exists in which protected registers are writable before security firmware runs.

Parameters:
NUM_REGS, 6, number of 32-bit lock words
DATA_W, 32, width of each lock word
IDX_W, 3, width of the register index (must satisfy 2**IDX_W >= NUM_REGS)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
boot_done_i  in  1  level; secure-boot firmware finished
seal_i  in  1  single-cycle pulse; freeze lock configuration
jtag_unlock_i  in  1  level; authenticated debug session active
fw_req_i  in  1  firmware write request
fw_idx_i  in  IDX_W  firmware target lock word
fw_wdata_i  in  DATA_W  firmware write data
fw_gnt_o  out  1  firmware write accepted (1-cycle pulse)
fw_err_o  out  1  firmware write rejected (1-cycle pulse)
dbg_req_i  in  1  debug write request
dbg_idx_i  in  IDX_W  debug target lock word
dbg_wdata_i  in  DATA_W  debug write data
dbg_gnt_o  out  1  debug write accepted
dbg_err_o  out  1  debug write rejected
reglk_o  out  NUM_REGS x DATA_W  lock words; 1 = locked
state_o  out  2  current lifecycle state

Behaviour:
- Reset (async assert, sync deassert handled upstream): all reglk_o words = 'hFFFF_FFFF; state BOOT_LOCK (0); all gnt/err = 0.
- States: BOOT_LOCK=0, CONFIG=1, SEALED=2, DEBUG=3.
- BOOT_LOCK -> CONFIG when boot_done_i = 1. All requests are rejected.
- CONFIG: firmware writes replace the word (reglk[idx] <= wdata). Debug requests are rejected. seal_i -> SEALED.
- SEALED: firmware writes are OR-merged (reglk[idx] <= reglk[idx] | wdata). A write that would clear a bit still grants; the clear is silently dropped. Debug requests are rejected.
- jtag_unlock_i rising edge in CONFIG or SEALED: all words forced to ones and state -> DEBUG in the same cycle. Any request in that cycle is rejected.
- DEBUG: only debug writes are accepted (replace semantics). Firmware requests are rejected.
- jtag_unlock_i falling edge in DEBUG: all words forced to ones and state -> SEALED. jtag_unlock_i in BOOT_LOCK is ignored.
- Handshake:
  - A request sampled at cycle N gets exactly one of gnt/err as a 1-cycle pulse at N+1.
  - The reglk_o update is visible at N+1.
  - The requester holds req/idx/wdata stable until it sees gnt or err.
  - A requester is never granted or rejected in two consecutive cycles. Its req is ignored in the cycle its response is high.
- idx >= NUM_REGS -> err, no write.
- Arbitration: at most one write per cycle.
  - When both requests are eligible in the same cycle (only possible for any rejection pairs; writes are state-exclusive), the round-robin pointer picks the winner. The loser waits.
  - Rejections do not consume the write slot. Both err pulses may fire together.
- Force-to-ones events (reset, DEBUG entry/exit) take priority over any write in the same cycle.
- Priority when events coincide: reset > jtag edges > seal_i > boot_done_i.
- seal_i outside CONFIG: ignored.

Optional Feature:
REGLK_AUDIT_EN
- Defined: adds output reject_cnt_o (8 bits), a saturating count (holds at 255) of rejected requests from both masters. Cleared only by rst_i. Adds output last_reject_src_o (1 bit: 0 = fw, 1 = dbg).
- Undefined: neither port nor counter exists. No other behaviour changes.

Decomposition:
- Package reglk_ctrl_pkg holds:
  - lifecycle state enum (BOOT_LOCK, CONFIG, SEALED, DEBUG);
  - LOCK_ALL = {DATA_W{1'b1}};
  - default NUM_REGS/DATA_W constants;
  - request-source enum (SRC_FW, SRC_DBG).
- One sub-module: reglk_rr_arb, a 2-way round-robin arbiter with a registered last-winner pointer.

Test Plan:
- Reset, then idle 5 cycles -> all 6 reglk_o words = 'hFFFF_FFFF, state_o = 0, no gnt/err.
- fw write idx 2 data 'h0000_00F0 in BOOT_LOCK -> fw_err_o at N+1, word 2 unchanged; assert boot_done_i and repeat -> fw_gnt_o, word 2 = 'h0000_00F0.
- In CONFIG, pulse seal_i, then fw write idx 2 data 'h0000_000F -> gnt, word 2 = 'h0000_00FF; fw write idx 6 -> err.
- In SEALED, raise jtag_unlock_i -> state_o = 3, all words 'hFFFF_FFFF next cycle; dbg write idx 0 data 0 -> gnt, word 0 = 0; drop jtag_unlock_i -> state_o = 2, word 0 = 'hFFFF_FFFF.
- fw and dbg requests both rejected in the same cycle, and a fw write coinciding with a jtag rising edge -> fw_err_o and dbg_err_o pulse together; the coinciding write is dropped and the words read all-ones.
- Assert rst_i mid-request in DEBUG -> outputs return to reset values asynchronously; state_o = 0.

Source files
------------

// File: rtl/reglk_ctrl_pkg.sv
// Shared types and constants for the register-lock controller.
//   lc_state_e : lifecycle state (BOOT_LOCK, CONFIG, SEALED, DEBUG)
//   req_src_e  : request source (SRC_FW, SRC_DBG)
//   LOCK_ALL   : all-ones lock word for the default word width
package reglk_ctrl_pkg;
  localparam int NUM_REGS_DEF = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int IDX_W_DEF    = 3;
  localparam logic [DATA_W_DEF-1:0] LOCK_ALL = {DATA_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    BOOT_LOCK = 2'd0,
    CONFIG    = 2'd1,
    SEALED    = 2'd2,
    DEBUG     = 2'd3
  } lc_state_e;

  typedef enum logic {
    SRC_FW  = 1'b0,
    SRC_DBG = 1'b1
  } req_src_e;
endpackage

// File: rtl/reglk_rr_arb.sv
// 2-way round-robin arbiter with a registered last-winner pointer.
//   clk_i, rst_i : clock, async active-high reset
//   req [1:0]    : requests (bit index = req_src_e)
//   gnt [1:0]    : one-hot grant, combinational
module reglk_rr_arb
  import reglk_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  req_src_e last_q;

  // On contention the source that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_q == SRC_DBG) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          last_q <= SRC_DBG;   // firmware wins the first tie
    else if (gnt[0])    last_q <= SRC_FW;
    else if (gnt[1])    last_q <= SRC_DBG;
  end
endmodule

// File: rtl/reglk_ctrl.sv
// Register-lock controller: owns the reglk lock-word array, arbitrates
// firmware and JTAG-debug lock-word writes, and sequences the lifecycle
// BOOT_LOCK -> CONFIG -> SEALED <-> DEBUG. Every word is forced to all-ones
// on reset and on each debug entry/exit.
//   clk_i, rst_i               : clock, async active-high reset
//   boot_done_i, seal_i        : lifecycle controls
//   jtag_unlock_i              : authenticated debug session level
//   fw_*  / dbg_*              : req/idx/wdata in, gnt/err 1-cycle pulses out
//   reglk_o                    : lock words, 1 = locked
//   state_o                    : lifecycle state
// Optional build macro REGLK_AUDIT_EN adds reject_cnt_o (saturating count of
// rejected requests) and last_reject_src_o (0 = fw, 1 = dbg).
module reglk_ctrl
  import reglk_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             boot_done_i,
  input  logic                             seal_i,
  input  logic                             jtag_unlock_i,
  input  logic                             fw_req_i,
  input  logic [IDX_W-1:0]                 fw_idx_i,
  input  logic [DATA_W-1:0]                fw_wdata_i,
  output logic                             fw_gnt_o,
  output logic                             fw_err_o,
  input  logic                             dbg_req_i,
  input  logic [IDX_W-1:0]                 dbg_idx_i,
  input  logic [DATA_W-1:0]                dbg_wdata_i,
  output logic                             dbg_gnt_o,
  output logic                             dbg_err_o,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  reglk_o,
  output logic [1:0]                       state_o
`ifdef REGLK_AUDIT_EN
  ,
  output logic [7:0]                       reject_cnt_o,
  output logic                             last_reject_src_o
`endif
);
  lc_state_e                       state_q, state_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] reglk_q;
  logic jtag_q, fw_gnt_q, fw_err_q, dbg_gnt_q, dbg_err_q;
  logic jtag_rise, jtag_fall, force_ones;
  logic fw_act, dbg_act, fw_elig, dbg_elig, fw_rej, dbg_rej;
  logic [1:0]        wr_gnt;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign jtag_rise  = jtag_unlock_i & ~jtag_q;
  assign jtag_fall  = ~jtag_unlock_i & jtag_q;
  // A debug edge in BOOT_LOCK is ignored, so it never forces.
  assign force_ones = (jtag_rise && (state_q == CONFIG || state_q == SEALED)) ||
                      (jtag_fall && state_q == DEBUG);

  // A requester's req is not looked at while its own response is high.
  assign fw_act  = fw_req_i  & ~fw_gnt_q  & ~fw_err_q;
  assign dbg_act = dbg_req_i & ~dbg_gnt_q & ~dbg_err_q;

  // Anything active but not write-eligible is rejected outright; rejects
  // never enter the arbiter, so both err pulses can fire together.
  assign fw_elig  = fw_act && !force_ones && (int'(fw_idx_i) < NUM_REGS) &&
                    (state_q == CONFIG || state_q == SEALED);
  assign dbg_elig = dbg_act && !force_ones && (int'(dbg_idx_i) < NUM_REGS) &&
                    (state_q == DEBUG);
  assign fw_rej   = fw_act  & ~fw_elig;
  assign dbg_rej  = dbg_act & ~dbg_elig;

  reglk_rr_arb u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({dbg_elig, fw_elig}),
    .gnt   (wr_gnt)
  );

  // Once sealed, firmware can only set lock bits: clears are OR-ed away.
  always_comb begin
    wr_idx  = fw_idx_i;
    wr_data = fw_wdata_i;
    if (wr_gnt[1]) begin
      wr_idx  = dbg_idx_i;
      wr_data = dbg_wdata_i;
    end else if (state_q == SEALED) begin
      wr_data = reglk_q[fw_idx_i] | fw_wdata_i;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                 reglk_q[i] <= '1;
      else if (force_ones)                       reglk_q[i] <= '1;
      else if ((|wr_gnt) && wr_idx == IDX_W'(i)) reglk_q[i] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT_LOCK: if (boot_done_i) state_d = CONFIG;
      CONFIG: begin
        if (jtag_rise)   state_d = DEBUG;
        else if (seal_i) state_d = SEALED;
      end
      SEALED:    if (jtag_rise) state_d = DEBUG;
      DEBUG:     if (jtag_fall) state_d = SEALED;
      default:   state_d = BOOT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= BOOT_LOCK;
      jtag_q    <= 1'b0;
      fw_gnt_q  <= 1'b0;
      fw_err_q  <= 1'b0;
      dbg_gnt_q <= 1'b0;
      dbg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jtag_q    <= jtag_unlock_i;
      fw_gnt_q  <= wr_gnt[0];
      fw_err_q  <= fw_rej;
      dbg_gnt_q <= wr_gnt[1];
      dbg_err_q <= dbg_rej;
    end
  end

  assign fw_gnt_o  = fw_gnt_q;
  assign fw_err_o  = fw_err_q;
  assign dbg_gnt_o = dbg_gnt_q;
  assign dbg_err_o = dbg_err_q;
  assign reglk_o   = reglk_q;
  assign state_o   = state_q;

`ifdef REGLK_AUDIT_EN
  logic [7:0] rej_cnt_q;
  logic       last_src_q;
  logic [8:0] cnt_sum;

  // Both masters can be rejected in one cycle, so the step may be 2.
  assign cnt_sum = {1'b0, rej_cnt_q} + {8'd0, fw_rej} + {8'd0, dbg_rej};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rej_cnt_q  <= 8'd0;
      last_src_q <= SRC_FW;
    end else begin
      rej_cnt_q <= (cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0];
      // A simultaneous double reject records the debug master.
      if (dbg_rej)     last_src_q <= SRC_DBG;
      else if (fw_rej) last_src_q <= SRC_FW;
    end
  end

  assign reject_cnt_o      = rej_cnt_q;
  assign last_reject_src_o = last_src_q;
`endif
endmodule
